// File: rtl/sar_ctrl_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_ctrl_gen_pkg
// Description : Shared SAR controller definitions: state encodings, state
//               width and default resolution / sample-window widths.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_ctrl_gen_pkg;

  localparam int C_STATE_W      = 2;
  localparam int C_DEF_BITS     = 10;
  localparam int C_DEF_SAMPLE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_t;

endpackage
`default_nettype wire

// File: rtl/sar_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : sar_sample_timer
// Description : Loadable down-counter timing the sample window. Loaded with
//               the window length L, it flags done during the last of the
//               L counting cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_sample_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Count down while enabled; load has priority, zero is a resting value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == W'(1));

endmodule
`default_nettype wire

// File: rtl/sar_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : sar_ctrl_gen
// Description : SAR conversion controller. Sequences sampling, a BITS-step
//               binary search driving the cap-DAC switches from the
//               comparator, and a result/valid handoff. Supports single-shot
//               and continuous operation with a programmable sample window.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_ctrl_gen
  import sar_ctrl_gen_pkg::*;
#(
  parameter int BITS     = C_DEF_BITS,
  parameter int SAMPLE_W = C_DEF_SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmp_decision,
  input  logic                start,
  input  logic                continuous,
  input  logic [SAMPLE_W-1:0] sample_len,
  output logic                clk_sample,
  output logic                busy,
  output logic [BITS-1:0]     result,
  output logic                result_valid,
  output logic [BITS-1:0]     switch_p,
  output logic [BITS-1:0]     switch_n,
  output logic [BITS-1:0]     switch_bp,
  output logic [BITS-1:0]     switch_bn,
  output logic [BITS-1:0]     switch_refp,
  output logic [BITS-1:0]     switch_refn
);

  localparam logic [BITS-1:0] c_ptr_msb = {1'b1, {(BITS-1){1'b0}}};

  sar_state_t          r_state;
  sar_state_t          w_state_next;
  logic                w_enter_sample;
  logic                w_to_convert;
  logic                w_last_bit;
  logic                w_timer_done;
  logic [SAMPLE_W-1:0] w_len;
  logic [BITS-1:0]     w_code_next;

  logic                r_clk_sample;
  logic [BITS-1:0]     r_pointer;
  logic [BITS-1:0]     r_code;
  logic [BITS-1:0]     r_result;
  logic [BITS-1:0]     r_switch_p;
  logic [BITS-1:0]     r_switch_n;

  // A zero window length still samples for one cycle.
  assign w_len = (sample_len == '0) ? SAMPLE_W'(1) : sample_len;

  // Code including the bit being decided this cycle; used for the final handoff.
  assign w_code_next = cmp_decision ? (r_code | r_pointer) : r_code;

  sar_sample_timer #(
    .W (SAMPLE_W)
  ) u_sample_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (w_enter_sample),
    .i_load_val (w_len),
    .i_en       (r_state == ST_SAMPLE),
    .o_done     (w_timer_done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the transition strobes that steer the datapath.
  always_comb begin
    w_state_next   = r_state;
    w_enter_sample = 1'b0;
    w_to_convert   = 1'b0;
    w_last_bit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || continuous) begin
          w_state_next   = ST_SAMPLE;
          w_enter_sample = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (w_timer_done) begin
          w_state_next = ST_CONVERT;
          w_to_convert = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (r_pointer[0]) begin
          w_state_next = ST_DONE;
          w_last_bit   = 1'b1;
        end
      end
      ST_DONE: begin
        if (continuous) begin
          w_state_next   = ST_SAMPLE;
          w_enter_sample = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Sample strobe, bit pointer, switch registers and code/result capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_clk_sample <= 1'b0;
      r_pointer    <= '0;
      r_code       <= '0;
      r_result     <= '0;
      r_switch_p   <= '0;
      r_switch_n   <= '0;
    end else begin
      r_clk_sample <= (w_state_next == ST_SAMPLE);

      if (w_enter_sample) begin
        r_switch_p <= '0;
        r_switch_n <= '0;
        r_code     <= '0;
      end else if (r_state == ST_CONVERT) begin
        // Each pointer position is visited once, so a bit lands on exactly one side.
        if (cmp_decision) begin
          r_switch_p <= r_switch_p | r_pointer;
        end else begin
          r_switch_n <= r_switch_n | r_pointer;
        end
        r_code <= w_code_next;
      end

      if (w_to_convert) begin
        r_pointer <= c_ptr_msb;
      end else if (r_state == ST_CONVERT) begin
        r_pointer <= r_pointer >> 1;
      end

      if (w_last_bit) begin
        r_result <= w_code_next;
      end
    end
  end

  assign clk_sample   = r_clk_sample;
  assign busy         = (r_state != ST_IDLE);
  assign result_valid = (r_state == ST_DONE);
  assign result       = r_result;
  assign switch_p     = r_switch_p;
  assign switch_n     = r_switch_n;
  assign switch_bp    = ~r_switch_p;
  assign switch_bn    = ~r_switch_n;
  assign switch_refp  = ~(r_switch_p | r_switch_n);
  assign switch_refn  = r_switch_p | r_switch_n;

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_ctrl_gen
// Description : Directed self-checking bench for sar_ctrl_gen with a result
//               scoreboard fed at stimulus time and drained on result_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl_gen;

  localparam int BITS = 10;
  localparam int SW   = 3;

  logic            clock        = 1'b0;
  logic            reset_n      = 1'b0;
  logic            cmp_decision = 1'b0;
  logic            start        = 1'b0;
  logic            continuous   = 1'b0;
  logic [SW-1:0]   sample_len   = '0;
  logic            clk_sample;
  logic            busy;
  logic [BITS-1:0] result;
  logic            result_valid;
  logic [BITS-1:0] switch_p;
  logic [BITS-1:0] switch_n;
  logic [BITS-1:0] switch_bp;
  logic [BITS-1:0] switch_bn;
  logic [BITS-1:0] switch_refp;
  logic [BITS-1:0] switch_refn;

  int              total  = 0;
  int              bad    = 0;
  int              pulses = 0;
  int              cyc_n  = 0;
  int              rv_cyc[$];
  logic [BITS-1:0] exp_q[$];

  sar_ctrl_gen #(
    .BITS     (BITS),
    .SAMPLE_W (SW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmp_decision (cmp_decision),
    .start        (start),
    .continuous   (continuous),
    .sample_len   (sample_len),
    .clk_sample   (clk_sample),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .switch_p     (switch_p),
    .switch_n     (switch_n),
    .switch_bp    (switch_bp),
    .switch_bn    (switch_bn),
    .switch_refp  (switch_refp),
    .switch_refn  (switch_refn)
  );

  always #5 clock = ~clock;

  // Edge counter used to time result_valid pulses.
  always @(posedge clock) cyc_n++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every result_valid pulse must match the oldest expected code.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && result_valid === 1'b1) begin
      pulses++;
      rv_cyc.push_back(cyc_n);
      chk("rv_has_expect", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_result", 32'(result), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Called just after the edge that enters SAMPLE; leaves the bench in the DONE cycle.
  // poke=1 pulses start and changes sample_len mid-CONVERT; poke=2 drops continuous.
  task automatic do_conv(input int len, input logic [BITS-1:0] tgt, input int poke);
    logic [BITS-1:0] inv;
    inv = ~tgt;
    exp_q.push_back(tgt);
    chk("sample_clear_p", 32'(switch_p), 32'd0);
    chk("sample_clear_n", 32'(switch_n), 32'd0);
    for (int i = 0; i < len; i++) begin
      chk("clk_sample_hi", 32'(clk_sample), 32'd1);
      cyc();
    end
    chk("clk_sample_lo", 32'(clk_sample), 32'd0);
    chk("busy_convert", 32'(busy), 32'd1);
    for (int i = 0; i < BITS; i++) begin
      cmp_decision = tgt[BITS-1-i];
      if (poke == 1 && i == 3) begin
        start      = 1'b1;
        sample_len = 3'd5;
      end
      if (poke == 2 && i == 4) continuous = 1'b0;
      if (i == BITS-1) chk("rv_early", 32'(result_valid), 32'd0);
      cyc();
      start = 1'b0;
    end
    chk("rv_done", 32'(result_valid), 32'd1);
    chk("done_result", 32'(result), 32'(tgt));
    chk("done_sw_p", 32'(switch_p), 32'(tgt));
    chk("done_sw_n", 32'(switch_n), 32'(inv));
    chk("done_sw_bp", 32'(switch_bp), 32'(inv));
    chk("done_sw_bn", 32'(switch_bn), 32'(tgt));
    chk("done_refp", 32'(switch_refp), 32'd0);
    chk("done_refn", 32'(switch_refn), 32'h3FF);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_sample", 32'(clk_sample), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_refp", 32'(switch_refp), 32'h3FF);
    chk("rst_refn", 32'(switch_refn), 32'd0);
    chk("rst_bp", 32'(switch_bp), 32'h3FF);
    chk("rst_bn", 32'(switch_bn), 32'h3FF);
    reset_n = 1'b1;
    cyc();
    chk("idle_hold", 32'(busy), 32'd0);

    // Single-shot, L=2, code 0x2CA
    sample_len = 3'd2;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    do_conv(2, 10'h2CA, 0);
    cyc();
    chk("ss_idle_busy", 32'(busy), 32'd0);
    chk("ss_idle_rv", 32'(result_valid), 32'd0);
    chk("ss_result_held", 32'(result), 32'h2CA);

    // Reset held for 2 cycles in the middle of CONVERT
    sample_len = 3'd3;
    start      = 1'b1;
    cyc();
    start        = 1'b0;
    cmp_decision = 1'b1;
    repeat (7) cyc();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rv", 32'(result_valid), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_sw_p", 32'(switch_p), 32'd0);
      chk("mid_rst_refp", 32'(switch_refp), 32'h3FF);
      chk("mid_rst_clk_sample", 32'(clk_sample), 32'd0);
    end
    reset_n = 1'b1;
    repeat (4) begin
      cyc();
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("post_rst_pulses", 32'(pulses), 32'd1);

    // Continuous, sample_len=0 treated as 1, three back-to-back conversions
    sample_len = 3'd0;
    continuous = 1'b1;
    cyc();
    do_conv(1, 10'h155, 0);
    cyc();
    do_conv(1, 10'h0AA, 0);
    cyc();
    do_conv(1, 10'h3C3, 0);
    continuous = 1'b0;
    cyc();
    chk("cont_idle_busy", 32'(busy), 32'd0);
    chk("cont_pulses", 32'(pulses), 32'd4);
    chk("cont_period_a", 32'(rv_cyc[2] - rv_cyc[1]), 32'd12);
    chk("cont_period_b", 32'(rv_cyc[3] - rv_cyc[2]), 32'd12);

    // Extremes
    sample_len = 3'd1;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    do_conv(1, 10'h3FF, 0);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    do_conv(1, 10'h000, 0);
    cyc();

    // start pulsed and sample_len changed mid-CONVERT: ignored, next uses L=5
    sample_len = 3'd2;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    do_conv(2, 10'h1E7, 1);
    cyc();
    chk("nq_busy_a", 32'(busy), 32'd0);
    cyc();
    chk("nq_busy_b", 32'(busy), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    do_conv(5, 10'h019, 0);
    cyc();
    chk("l5_idle_busy", 32'(busy), 32'd0);

    // continuous dropped mid-CONVERT: conversion completes, then IDLE
    sample_len = 3'd1;
    continuous = 1'b1;
    cyc();
    do_conv(1, 10'h2A5, 2);
    cyc();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_clk_sample", 32'(clk_sample), 32'd0);
    repeat (3) begin
      cyc();
      chk("drop_stay_idle", 32'(busy), 32'd0);
    end
    chk("final_pulses", 32'(pulses), 32'd9);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
